// File: rtl/plat_load_ctrl_if.sv
// Platform ROM read bus.
//   master (controller): drives rom_rd/rom_type/rom_idx and receives rom_x/rom_y/rom_len.
//   slave  (ROM):        returns data one cycle after rom_rd.
interface plat_load_ctrl_if #(
  parameter int PHY_WIDTH       = 16,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int TYPE_WIDTH      = 4,
  parameter int IDX_WIDTH       = 3
);
  logic                       rom_rd;
  logic [TYPE_WIDTH-1:0]      rom_type;
  logic [IDX_WIDTH-1:0]       rom_idx;
  logic [PHY_WIDTH-1:0]       rom_x;
  logic [PHY_WIDTH-1:0]       rom_y;
  logic [BLOCK_LEN_WIDTH-1:0] rom_len;

  modport master (output rom_rd, rom_type, rom_idx, input rom_x, rom_y, rom_len);
  modport slave  (input rom_rd, rom_type, rom_idx, output rom_x, rom_y, rom_len);
endinterface

// File: rtl/plat_load_ctrl.sv
// plat_load_ctrl: per-block platform table loader.
//   On block_switch, walks ROM indices 0..N-1 into a shadow bank, then copies the
//   shadow into the active bank on the next frame_sync so consumers never see a
//   partially loaded table.
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   block_switch/block_type_in new block request (type sampled with the pulse)
//   frame_sync                vertical-blank pulse, swap point
//   rom                       ROM read bus (plat_load_ctrl_if.master)
//   busy                      loading or waiting to swap
//   table_valid               active bank holds a complete table (sticky)
//   swap_pulse                high for the first cycle the new active bank is visible
//   active_x/active_y/active_len packed tables, platform i at [i*W +: W]
// Optional: define PLAT_LOAD_ABORT_CNT_EN to add abort_cnt[7:0], a saturating
//   count of block_switch pulses that interrupt a load (FETCH or ARMED).
module plat_load_ctrl #(
  parameter int PLATFORM_NUM_PER_BLOCK = 7,
  parameter int PHY_WIDTH              = 16,
  parameter int BLOCK_LEN_WIDTH        = 4,
  parameter int TYPE_WIDTH             = 4,
  parameter int IDX_WIDTH              = 3
) (
  input  logic                                        sys_clk,
  input  logic                                        sys_rst,
  input  logic                                        block_switch,
  input  logic [TYPE_WIDTH-1:0]                       block_type_in,
  input  logic                                        frame_sync,
  plat_load_ctrl_if.master                            rom,
  output logic                                        busy,
  output logic                                        table_valid,
  output logic                                        swap_pulse,
  output logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] active_x,
  output logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] active_y,
  output logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] active_len
`ifdef PLAT_LOAD_ABORT_CNT_EN
  ,
  output logic [7:0]                                  abort_cnt
`endif
);
  localparam int N = PLATFORM_NUM_PER_BLOCK;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ARMED} state_t;
  state_t r_state, w_state_nxt;

  logic [TYPE_WIDTH-1:0] r_type;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic                  r_issue;     // still issuing reads in this load
  logic                  r_cap_vld;   // ROM data on the bus this cycle belongs to r_cap_idx
  logic [IDX_WIDTH-1:0]  r_cap_idx;
  logic                  r_table_valid;
  logic                  r_swap_pulse;

  logic [N-1:0][PHY_WIDTH-1:0]       r_shd_x, r_shd_y, r_act_x, r_act_y;
  logic [N-1:0][BLOCK_LEN_WIDTH-1:0] r_shd_len, r_act_len;

  logic w_rd, w_swap, w_cap_last;

  assign w_rd       = (r_state == S_FETCH) && r_issue;
  // Restart has priority over swap when both pulses coincide.
  assign w_swap     = (r_state == S_ARMED) && frame_sync && !block_switch;
  assign w_cap_last = r_cap_vld && (r_cap_idx == LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (block_switch) w_state_nxt = S_FETCH;
      S_FETCH: if (block_switch)    w_state_nxt = S_FETCH;
               else if (w_cap_last) w_state_nxt = S_ARMED;
      S_ARMED: if (block_switch)    w_state_nxt = S_FETCH;
               else if (frame_sync) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_type        <= '0;
      r_idx         <= '0;
      r_issue       <= 1'b0;
      r_cap_vld     <= 1'b0;
      r_cap_idx     <= '0;
      r_table_valid <= 1'b0;
      r_swap_pulse  <= 1'b0;
      r_shd_x       <= '0;
      r_shd_y       <= '0;
      r_shd_len     <= '0;
      r_act_x       <= '0;
      r_act_y       <= '0;
      r_act_len     <= '0;
    end else begin
      r_swap_pulse <= w_swap;
      if (block_switch) begin
        // Restart: in-flight capture is dropped so stale data never lands.
        r_type    <= block_type_in;
        r_idx     <= '0;
        r_issue   <= 1'b1;
        r_cap_vld <= 1'b0;
      end else begin
        r_cap_vld <= w_rd;
        r_cap_idx <= r_idx;
        if (w_rd) begin
          if (r_idx == LAST) r_issue <= 1'b0;   // hold at N-1, no wrap
          else               r_idx   <= r_idx + 1'b1;
        end
        if (r_cap_vld) begin
          r_shd_x[r_cap_idx]   <= rom.rom_x;
          r_shd_y[r_cap_idx]   <= rom.rom_y;
          r_shd_len[r_cap_idx] <= rom.rom_len;
        end
      end
      if (w_swap) begin
        r_act_x       <= r_shd_x;
        r_act_y       <= r_shd_y;
        r_act_len     <= r_shd_len;
        r_table_valid <= 1'b1;
      end
    end
  end

`ifdef PLAT_LOAD_ABORT_CNT_EN
  logic [7:0] r_abort_cnt;
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      r_abort_cnt <= '0;
    else if (block_switch && (r_state != S_IDLE) && (r_abort_cnt != 8'hFF))
      r_abort_cnt <= r_abort_cnt + 8'd1;
  end
  assign abort_cnt = r_abort_cnt;
`endif

  assign rom.rom_rd   = w_rd;
  assign rom.rom_type = r_type;
  assign rom.rom_idx  = r_idx;
  assign busy         = (r_state != S_IDLE);
  assign table_valid  = r_table_valid;
  assign swap_pulse   = r_swap_pulse;
  assign active_x     = r_act_x;
  assign active_y     = r_act_y;
  assign active_len   = r_act_len;
endmodule

// File: tb/tb_plat_load_ctrl.sv
// Bench for plat_load_ctrl: table-driven issue sequence plus a swap scoreboard.
module tb_plat_load_ctrl;
  localparam int N = 7;

  logic sys_clk = 1'b0;
  logic sys_rst, block_switch, frame_sync;
  logic [3:0] block_type_in;
  logic busy, table_valid, swap_pulse;
  logic [N*16-1:0] active_x, active_y;
  logic [N*4-1:0]  active_len;
`ifdef PLAT_LOAD_ABORT_CNT_EN
  logic [7:0] abort_cnt;
`endif

  always #5 sys_clk = ~sys_clk;

  plat_load_ctrl_if rom_if();

  plat_load_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .block_switch(block_switch),
    .block_type_in(block_type_in), .frame_sync(frame_sync), .rom(rom_if),
    .busy(busy), .table_valid(table_valid), .swap_pulse(swap_pulse),
    .active_x(active_x), .active_y(active_y), .active_len(active_len)
`ifdef PLAT_LOAD_ABORT_CNT_EN
    , .abort_cnt(abort_cnt)
`endif
  );

  // ROM model: x=10*idx, y=16*type+idx, len=type; data one cycle after rd.
  always @(posedge sys_clk) begin
    if (rom_if.rom_rd) begin
      rom_if.rom_x   <= 16'(10 * rom_if.rom_idx);
      rom_if.rom_y   <= 16'(rom_if.rom_type * 16 + rom_if.rom_idx);
      rom_if.rom_len <= rom_if.rom_type;
    end
  end

  typedef struct packed {
    logic [N*16-1:0] x;
    logic [N*16-1:0] y;
    logic [N*4-1:0]  len;
  } tab_t;

  typedef struct {
    logic       rd;
    logic [2:0] idx;
    logic       busy;
  } vec_t;

  tab_t sbq[$];
  int n_run = 0, n_fail = 0, swaps = 0;

  function automatic tab_t mk(int t);
    tab_t r;
    for (int i = 0; i < N; i++) begin
      r.x[i*16 +: 16] = 16'(10 * i);
      r.y[i*16 +: 16] = 16'(t * 16 + i);
      r.len[i*4 +: 4] = 4'(t);
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, score any swap.
  task automatic step();
    tab_t e;
    @(posedge sys_clk);
    #1;
    if (swap_pulse === 1'b1) begin
      swaps++;
      if (sbq.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL unexpected_swap: got swap_pulse=1 expected 0");
      end else begin
        e = sbq.pop_front();
        chk("sb_x", 128'(active_x), 128'(e.x));
        chk("sb_y", 128'(active_y), 128'(e.y));
        chk("sb_len", 128'(active_len), 128'(e.len));
      end
    end
  endtask

  // Issue block_switch; a restarted load never swaps, so it replaces the pending entry.
  task automatic load(int t);
    block_switch  = 1'b1;
    block_type_in = 4'(t);
    if (sbq.size() > 0) void'(sbq.pop_back());
    sbq.push_back(mk(t));
    step();
    block_switch = 1'b0;
  endtask

  task automatic fs_pulse();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
  endtask

  vec_t vec[9];
  int s0;
  tab_t t2, t3;

  initial begin
    // Cycle k after block_switch: expected rd / idx / busy.
    for (int k = 0; k < 9; k++) begin
      vec[k].rd   = (k <= 6);
      vec[k].idx  = (k <= 6) ? 3'(k) : 3'd6;
      vec[k].busy = 1'b1;
    end
    t2 = mk(2);
    t3 = mk(3);

    sys_rst = 1'b1; block_switch = 1'b0; frame_sync = 1'b0; block_type_in = '0;
    step(); step();
    sys_rst = 1'b0;
    chk("rst_rd", 128'(rom_if.rom_rd), 0);
    chk("rst_type", 128'(rom_if.rom_type), 0);
    chk("rst_idx", 128'(rom_if.rom_idx), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_tv", 128'(table_valid), 0);
    chk("rst_swap", 128'(swap_pulse), 0);
    chk("rst_ax", 128'(active_x), 0);

    // 1: basic load type 2, frame_sync during FETCH ignored, swap at first ARMED cycle
    s0 = swaps;
    load(2);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t1_rd[%0d]", k), 128'(rom_if.rom_rd), 128'(vec[k].rd));
      chk($sformatf("t1_idx[%0d]", k), 128'(rom_if.rom_idx), 128'(vec[k].idx));
      chk($sformatf("t1_busy[%0d]", k), 128'(busy), 128'(vec[k].busy));
      if (k < 8) begin
        frame_sync = (k == 3);
        step();
        frame_sync = 1'b0;
      end
    end
    chk("t1_type", 128'(rom_if.rom_type), 2);
    chk("t1_ax_hold", 128'(active_x), 0);
    chk("t1_noswap_fetch", 128'(swaps - s0), 0);
    fs_pulse();
    chk("t1_swap", 128'(swap_pulse), 1);
    chk("t1_tv", 128'(table_valid), 1);
    chk("t1_busy_idle", 128'(busy), 0);
    step();
    chk("t1_swap_1cyc", 128'(swap_pulse), 0);

    // 2: frame_sync on FETCH->ARMED edge ignored; next one swaps
    load(1);
    repeat (7) step();
    s0 = swaps;
    fs_pulse();
    chk("t2_noswap", 128'(swap_pulse), 0);
    repeat (3) step();
    chk("t2_noswap_cnt", 128'(swaps - s0), 0);
    chk("t2_busy", 128'(busy), 1);
    chk("t2_old_x", 128'(active_x), 128'(t2.x));
    chk("t2_old_y", 128'(active_y), 128'(t2.y));
    fs_pulse();
    chk("t2_swap", 128'(swap_pulse), 1);
    step();

    // 3: abort type 0 at idx 4, restart as type 3
    load(0);
    repeat (4) step();
    chk("t3_idx4", 128'(rom_if.rom_idx), 4);
    load(3);
    chk("t3_restart_idx", 128'(rom_if.rom_idx), 0);
    chk("t3_restart_type", 128'(rom_if.rom_type), 3);
    repeat (8) step();
    fs_pulse();
    chk("t3_swap", 128'(swap_pulse), 1);
`ifdef PLAT_LOAD_ABORT_CNT_EN
    chk("t3_abort", 128'(abort_cnt), 1);
`endif
    step();

    // 4: ARMED with block_switch+frame_sync together: restart wins
    load(5);
    repeat (8) step();
    s0 = swaps;
    frame_sync = 1'b1;
    load(6);
    frame_sync = 1'b0;
    chk("t4_noswap", 128'(swaps - s0), 0);
    chk("t4_tv", 128'(table_valid), 1);
    chk("t4_rd", 128'(rom_if.rom_rd), 1);
    chk("t4_idx", 128'(rom_if.rom_idx), 0);
    chk("t4_type", 128'(rom_if.rom_type), 6);
    chk("t4_old_y", 128'(active_y), 128'(t3.y));
`ifdef PLAT_LOAD_ABORT_CNT_EN
    chk("t4_abort", 128'(abort_cnt), 2);
`endif
    repeat (8) step();
    fs_pulse();
    chk("t4_swap", 128'(swap_pulse), 1);
    step();

    // 5: reset mid-FETCH
    load(7);
    repeat (3) step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    sbq.delete();
    chk("t5_rd", 128'(rom_if.rom_rd), 0);
    chk("t5_idx", 128'(rom_if.rom_idx), 0);
    chk("t5_type", 128'(rom_if.rom_type), 0);
    chk("t5_busy", 128'(busy), 0);
    chk("t5_tv", 128'(table_valid), 0);
    chk("t5_ax", 128'(active_x), 0);
    chk("t5_ay", 128'(active_y), 0);
    chk("t5_alen", 128'(active_len), 0);
`ifdef PLAT_LOAD_ABORT_CNT_EN
    chk("t5_abort", 128'(abort_cnt), 0);
`endif
    s0 = swaps;
    fs_pulse();
    step();
    chk("t5_idle_noswap", 128'(swaps - s0), 0);

`ifdef PLAT_LOAD_ABORT_CNT_EN
    // 6: 300 back-to-back switches (first from IDLE is not an abort)
    for (int i = 0; i < 300; i++) load(i % 16);
    chk("t6_abort_sat", 128'(abort_cnt), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
